gate_op_arbiter: RTL and testbench

- Round-robin scheduler that shares one bitwise logic unit between NREQ requesters.
- Supported ops: AND, OR, NOT, NAND, NOR.
- Each requester presents an opcode and two operands with a valid/ready handshake.
- The block grants one requester per cycle, computes the result into a single-entry output register, and presents it downstream with valid/ready backpressure and the winner's ID.

---
 rtl/gate_op_arbiter.sv | 139 +++++++++++++
 tb/tb_gate_op_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/NOT/NAND/NOR)
// between NREQ requesters, with a single-entry registered output stage
// that supports valid/ready backpressure and reports the winner's index.
module gate_op_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 5,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_op,
  input  logic [WIDTH*NREQ-1:0]  req_a,
  input  logic [WIDTH*NREQ-1:0]  req_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic [IDW-1:0]         out_id,
  output logic                   out_err,
  output logic [15:0]            op_count
);

  // Output slot occupancy; FULL is exactly out_valid.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [IDW-1:0]     ptr;
  logic [IDW:0]       pick;
  logic               any_vld;
  logic [IDW-1:0]     win;
  logic               accept;
  logic               xfer;
  logic [2:0]         op_sel;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH:0]     res;
  logic [WIDTH-1:0]   y_p0;
  logic [IDW-1:0]     id_p0;
  logic               err_p0;
  logic [15:0]        cnt_p0;

  // First valid requester at or after p, wrapping; returns {found, index}.
  // The doubled vector rotated by p puts candidate k at bit k, so scanning
  // from the far end lets the nearest one overwrite the result.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                           input logic [IDW-1:0]  p);
    logic [2*NREQ-1:0] dbl;
    logic [IDW:0]      sum;
    logic [IDW:0]      r;
    dbl = {v, v} >> p;
    sum = '0;
    r   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        sum = {1'b0, p} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        r = {1'b1, sum[IDW-1:0]};
      end
    end
    return r;
  endfunction

  // Bitwise logic unit; returns {err, y}. Illegal opcodes force y to zero.
  function automatic logic [WIDTH:0] gate_op(input logic [2:0]       op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (op)
      3'd0:    r = {1'b0, a & b};
      3'd1:    r = {1'b0, a | b};
      3'd2:    r = {1'b0, ~a};
      3'd3:    r = {1'b0, ~(a & b)};
      3'd4:    r = {1'b0, ~(a | b)};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  assign pick      = rr_pick(req_valid, ptr);
  assign any_vld   = pick[IDW];
  assign win       = pick[IDW-1:0];
  assign out_valid = (state == FULL);
  assign accept    = !out_valid || out_ready;
  assign xfer      = any_vld && accept;

  // Grant is one-hot on the winner and suppressed entirely while in reset.
  always_comb begin
    req_ready = '0;
    if (xfer && rst_n) req_ready = NREQ'(1) << win;
  end

  // Winner's request fields feed the logic unit.
  always_comb begin
    op_sel = req_op[int'(win)*3 +: 3];
    a_sel  = req_a[int'(win)*WIDTH +: WIDTH];
    b_sel  = req_b[int'(win)*WIDTH +: WIDTH];
    res    = gate_op(op_sel, a_sel, b_sel);
  end

  // Slot state transitions: fill on transfer, empty only on drain without refill.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (xfer) state_nxt = FULL;
      FULL:    if (out_ready && !xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Stage p0: capture winner's result, advance pointer past winner, count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_p0   <= '0;
      id_p0  <= '0;
      err_p0 <= 1'b0;
      ptr    <= '0;
      cnt_p0 <= '0;
    end else if (xfer) begin
      y_p0   <= res[WIDTH-1:0];
      err_p0 <= res[WIDTH];
      id_p0  <= win;
      ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
      if (cnt_p0 != 16'hFFFF) cnt_p0 <= cnt_p0 + 16'd1;
    end
  end

  assign out_y    = y_p0;
  assign out_id   = id_p0;
  assign out_err  = err_p0;
  assign op_count = cnt_p0;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Testbench for gate_op_arbiter: table-driven op sweep, hand-written
// multi-cycle sequences, and a per-cycle scoreboard against a reference model.
module tb_gate_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 5;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_y;
  logic [IDW-1:0]        out_id;
  logic                  out_err;
  logic [15:0]           op_count;

  gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_id(out_id), .out_err(out_err),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] y;
    logic             err;
  } res_t;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             err;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic        m_valid;
  int          m_ptr;
  logic [15:0] m_cnt;
  res_t        q[$];
  res_t        last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic res_t model_op(input int id, input logic [2:0] op,
                                    input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    res_t r;
    r.id  = IDW'(id);
    r.err = 1'b0;
    if (op == 3'd0)      r.y = a & b;
    else if (op == 3'd1) r.y = a | b;
    else if (op == 3'd2) r.y = ~a;
    else if (op == 3'd3) r.y = ~(a & b);
    else if (op == 3'd4) r.y = ~(a | b);
    else begin r.y = '0; r.err = 1'b1; end
    return r;
  endfunction

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[i*3 +: 3]         = op;
    req_a[i*WIDTH +: WIDTH]  = a;
    req_b[i*WIDTH +: WIDTH]  = b;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = '0;
    q.delete();
    last    = '0;
  endtask

  // One clock: check grant and output against the model at the falling edge,
  // update the model for the coming rising edge, then check the counter.
  task automatic tick();
    int              w;
    logic            any;
    logic            xfer;
    logic [NREQ-1:0] exp_rdy;
    res_t            r;
    @(negedge clk);
    any = 1'b0;
    w   = 0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (!any && req_valid[idx]) begin any = 1'b1; w = idx; end
    end
    xfer    = any && (!m_valid || out_ready);
    exp_rdy = xfer ? (NREQ'(1) << w) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      if (q.size() == 0) chk("sb_nonempty", 0, 1);
      else begin
        chk("sb_y",   out_y,   q[0].y);
        chk("sb_id",  out_id,  q[0].id);
        chk("sb_err", out_err, q[0].err);
      end
    end else begin
      chk("hold_y",   out_y,   last.y);
      chk("hold_id",  out_id,  last.id);
      chk("hold_err", out_err, last.err);
    end
    if (m_valid && out_ready && q.size() != 0) last = q.pop_front();
    if (xfer) begin
      r = model_op(w, req_op[w*3 +: 3], req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH]);
      q.push_back(r);
      m_ptr = (w + 1) % NREQ;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    m_valid = xfer || (m_valid && !out_ready);
    @(posedge clk);
    #1;
    chk("op_count", op_count, m_cnt);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3'd0, 5'b10110, 5'b01100, 5'b00100, 1'b0};
    tbl[1] = '{3'd1, 5'b10110, 5'b01100, 5'b11110, 1'b0};
    tbl[2] = '{3'd2, 5'b10110, 5'b01100, 5'b01001, 1'b0};
    tbl[3] = '{3'd3, 5'b10110, 5'b01100, 5'b11011, 1'b0};
    tbl[4] = '{3'd4, 5'b10110, 5'b01100, 5'b00001, 1'b0};
    tbl[5] = '{3'd6, 5'h1F,    5'h1F,    5'h00,    1'b1};
    tbl[6] = '{3'd0, 5'h1F,    5'h1F,    5'h1F,    1'b0};
    tbl[7] = '{3'd5, 5'h0A,    5'h15,    5'h00,    1'b1};

    model_reset();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_count",  op_count,  0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_y",     out_y,     0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin: all four valid, grants 0,1,2,3,0,1,...
    for (int i = 0; i < NREQ; i++)
      set_req(i, 3'(i), WIDTH'($urandom_range(0, 31)), WIDTH'($urandom_range(0, 31)));
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_id", out_id, k % NREQ);
    end
    chk("rr_count8", op_count, 8);

    // Table-driven sweep on requester 2, back-to-back with out_ready high
    req_valid = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      set_req(2, tbl[i].op, tbl[i].a, tbl[i].b);
      tick();
      chk("sweep_y",   out_y,   tbl[i].y);
      chk("sweep_err", out_err, tbl[i].err);
      chk("sweep_id",  out_id,  2);
      chk("sweep_vld", out_valid, 1);
    end
    req_valid = '0;

    // Idle cycles after requester 2: pointer sits at 3
    for (int k = 0; k < 5; k++) tick();
    chk("idle_vld", out_valid, 0);
    set_req(0, 3'd1, 5'h03, 5'h10);
    set_req(3, 3'd3, 5'h0F, 5'h1C);
    req_valid = 4'b1001;
    tick();
    chk("wrap_first", out_id, 3);
    chk("wrap_first_y", out_y, 5'h13);
    req_valid = 4'b0001;
    tick();
    chk("wrap_second", out_id, 0);
    chk("wrap_second_y", out_y, 5'h13);
    req_valid = '0;
    tick();

    // Backpressure: requesters 1 and 3, out_ready low for 3 cycles
    out_ready = 1'b0;
    set_req(1, 3'd0, 5'h1E, 5'h0F);
    set_req(3, 3'd4, 5'h01, 5'h02);
    req_valid = 4'b1010;
    tick();
    chk("bp_id_first", out_id, 1);
    req_valid = 4'b1000;
    tick();
    tick();
    chk("bp_held_id", out_id, 1);
    chk("bp_held_y",  out_y,  5'h0E);
    chk("bp_held_ready", req_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("bp_next_id", out_id, 3);
    chk("bp_next_y",  out_y,  5'h1C);
    chk("bp_next_vld", out_valid, 1);
    req_valid = '0;
    tick();

    // Reset while a result is held
    out_ready = 1'b0;
    set_req(2, 3'd1, 5'h15, 5'h00);
    req_valid = 4'b0100;
    tick();
    chk("pre_rst_vld", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",   out_valid, 0);
    chk("mid_rst_y",     out_y,     0);
    chk("mid_rst_id",    out_id,    0);
    chk("mid_rst_cnt",   op_count,  0);
    chk("mid_rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    chk("in_rst_vld", out_valid, 0);
    chk("in_rst_ready", req_ready, 0);
    model_reset();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_id", out_id, 2);
    chk("post_rst_y",  out_y,  5'h15);
    req_valid = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
